vga_rasterizer: RTL and testbench

- Drawing engine upstream of the 214x160, 3-bit-per-pixel framebuffer SRAM; drives its write port while the VGA output controller reads through the read port.
- Accepts one draw command at a time over a valid/ready handshake: point, filled rectangle or full-screen clear.
- Expands each command into one pixel write per clock in raster order (x fastest), clipped to the framebuffer bounds.
- Future CPU command path connects to the command port.

---
 rtl/vga_rasterizer_pkg.sv | 42 ++++
 rtl/vga_rasterizer_if.sv | 24 ++
 rtl/vga_rasterizer.sv | 171 +++++++++++++++++
 tb/tb_vga_rasterizer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_rasterizer_pkg.sv
// Shared types, framebuffer geometry and the constant row-offset helper
// for the framebuffer drawing engine.
package vga_rasterizer_pkg;

    localparam int FB_WIDTH  = 214;
    localparam int FB_HEIGHT = 160;
    localparam int A_WIDTH   = 16;
    localparam int D_WIDTH   = 3;
    localparam int C_WIDTH   = 8;

    localparam logic [C_WIDTH-1:0] X_MAX     = 8'(FB_WIDTH - 1);
    localparam logic [C_WIDTH-1:0] Y_MAX     = 8'(FB_HEIGHT - 1);
    localparam logic [C_WIDTH-1:0] FB_W_BITS = 8'(FB_WIDTH);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_POINT = 2'b01,
        OP_RECT  = 2'b10,
        OP_CLEAR = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRAW   = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

    // y * FB_WIDTH as a fixed shift-add sum over the set bits of the width
    function automatic logic [A_WIDTH-1:0] row_base_f(input logic [C_WIDTH-1:0] y);
        logic [A_WIDTH-1:0] acc;
        acc = {A_WIDTH{1'b0}};
        for (int i = 0; i < C_WIDTH; i++) begin
            if (FB_W_BITS[i]) begin
                acc = acc + (A_WIDTH'(y) << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_rasterizer_if.sv
// Draw-command port: valid/ready handshake plus the command fields.
interface vga_rasterizer_if;
    import vga_rasterizer_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    cmd_op_t              cmd_op;
    logic [C_WIDTH-1:0]   cmd_x0;
    logic [C_WIDTH-1:0]   cmd_y0;
    logic [C_WIDTH-1:0]   cmd_x1;
    logic [C_WIDTH-1:0]   cmd_y1;
    logic [D_WIDTH-1:0]   cmd_color;

    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready
    );

endinterface

// File: rtl/vga_rasterizer.sv
// Expands point / rectangle / clear commands into one clipped framebuffer
// write per clock in raster order, using incremental address generation.
module vga_rasterizer
    import vga_rasterizer_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst_async,
    vga_rasterizer_if.slave      cmd_if,
    output logic [A_WIDTH-1:0]   fb_write_addr,
    output logic [D_WIDTH-1:0]   fb_write_data,
    output logic                 fb_write_en,
    output logic                 done
);

    state_t               state_q, state_d;
    logic [C_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [C_WIDTH-1:0]   x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
    logic [A_WIDTH-1:0]   row_base_q, row_base_d;
    logic [A_WIDTH-1:0]   fb_write_addr_q, fb_write_addr_d;
    logic [D_WIDTH-1:0]   fb_write_data_q, fb_write_data_d;
    logic                 fb_write_en_q, fb_write_en_d;
    logic                 done_q, done_d;
    logic                 cmd_ready_q, cmd_ready_d;

    logic [C_WIDTH-1:0]   nx0_s, ny0_s, nx1_s, ny1_s, cx1_s, cy1_s;
    logic                 nop_s, empty_s, last_s;
    logic [A_WIDTH-1:0]   first_base_s;

    // Command normalisation and clipping, evaluated against the live fields
    always_comb begin
        nx0_s = cmd_if.cmd_x0;
        ny0_s = cmd_if.cmd_y0;
        nx1_s = cmd_if.cmd_x1;
        ny1_s = cmd_if.cmd_y1;
        nop_s = 1'b0;
        case (cmd_if.cmd_op)
            OP_POINT: begin
                nx1_s = cmd_if.cmd_x0;
                ny1_s = cmd_if.cmd_y0;
            end
            OP_RECT: begin
                nop_s = 1'b0;
            end
            OP_CLEAR: begin
                nx0_s = 8'd0;
                ny0_s = 8'd0;
                nx1_s = X_MAX;
                ny1_s = Y_MAX;
            end
            OP_NOP:  nop_s = 1'b1;
            default: nop_s = 1'b1;
        endcase
        if (nx1_s > X_MAX) begin
            cx1_s = X_MAX;
        end else begin
            cx1_s = nx1_s;
        end
        if (ny1_s > Y_MAX) begin
            cy1_s = Y_MAX;
        end else begin
            cy1_s = ny1_s;
        end
        empty_s = nop_s || (nx0_s > X_MAX) || (ny0_s > Y_MAX)
                  || (nx0_s > cx1_s) || (ny0_s > cy1_s);
        first_base_s = row_base_f(ny0_s);
    end

    assign last_s = (x_q == x1_q) && (y_q == y1_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d         = state_q;
        x_d             = x_q;
        y_d             = y_q;
        x0_d            = x0_q;
        x1_d            = x1_q;
        y1_d            = y1_q;
        row_base_d      = row_base_q;
        fb_write_addr_d = fb_write_addr_q;
        fb_write_data_d = fb_write_data_q;
        fb_write_en_d   = 1'b0;
        done_d          = 1'b0;
        cmd_ready_d     = cmd_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid && empty_s) begin
                    state_d     = ST_FINISH;
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                end else if (cmd_if.cmd_valid) begin
                    state_d         = ST_DRAW;
                    x_d             = nx0_s;
                    y_d             = ny0_s;
                    x0_d            = nx0_s;
                    x1_d            = cx1_s;
                    y1_d            = cy1_s;
                    row_base_d      = first_base_s;
                    fb_write_addr_d = first_base_s + A_WIDTH'(nx0_s);
                    fb_write_data_d = cmd_if.cmd_color;
                    fb_write_en_d   = 1'b1;
                    cmd_ready_d     = 1'b0;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_DRAW: begin
                if (last_s) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end else if (x_q == x1_q) begin
                    // Wrap to the next row: step the row base rather than multiply
                    x_d             = x0_q;
                    y_d             = y_q + 8'd1;
                    row_base_d      = row_base_q + A_WIDTH'(FB_WIDTH);
                    fb_write_addr_d = row_base_q + A_WIDTH'(FB_WIDTH) + A_WIDTH'(x0_q);
                    fb_write_en_d   = 1'b1;
                end else begin
                    x_d             = x_q + 8'd1;
                    fb_write_addr_d = fb_write_addr_q + 16'd1;
                    fb_write_en_d   = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            state_q         <= ST_IDLE;
            x_q             <= 8'd0;
            y_q             <= 8'd0;
            x0_q            <= 8'd0;
            x1_q            <= 8'd0;
            y1_q            <= 8'd0;
            row_base_q      <= 16'd0;
            fb_write_addr_q <= 16'd0;
            fb_write_data_q <= 3'd0;
            fb_write_en_q   <= 1'b0;
            done_q          <= 1'b0;
            cmd_ready_q     <= 1'b1;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            x0_q            <= x0_d;
            x1_q            <= x1_d;
            y1_q            <= y1_d;
            row_base_q      <= row_base_d;
            fb_write_addr_q <= fb_write_addr_d;
            fb_write_data_q <= fb_write_data_d;
            fb_write_en_q   <= fb_write_en_d;
            done_q          <= done_d;
            cmd_ready_q     <= cmd_ready_d;
        end
    end

    assign cmd_if.cmd_ready = cmd_ready_q;
    assign fb_write_addr    = fb_write_addr_q;
    assign fb_write_data    = fb_write_data_q;
    assign fb_write_en      = fb_write_en_q;
    assign done             = done_q;

endmodule

// File: tb/tb_vga_rasterizer.sv
// Scoreboard bench for vga_rasterizer: expected pixel writes are queued per
// command and matched against the write port as it strobes.
module tb_vga_rasterizer;
    import vga_rasterizer_pkg::*;

    logic                 clk = 1'b0;
    logic                 n_rst_async;
    logic [A_WIDTH-1:0]   fb_write_addr;
    logic [D_WIDTH-1:0]   fb_write_data;
    logic                 fb_write_en;
    logic                 done;

    vga_rasterizer_if cmd_if();

    vga_rasterizer dut (
        .clk           (clk),
        .n_rst_async   (n_rst_async),
        .cmd_if        (cmd_if),
        .fb_write_addr (fb_write_addr),
        .fb_write_data (fb_write_data),
        .fb_write_en   (fb_write_en),
        .done          (done)
    );

    always #10 clk = ~clk;

    int checks_cnt = 0;
    int fail_cnt   = 0;
    int wr_cnt     = 0;
    int done_cnt   = 0;
    int exp_addr_q[$];
    int exp_data_q[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Write-port scoreboard
    always @(negedge clk) begin : mon
        int a;
        int d;
        if (fb_write_en) begin
            wr_cnt++;
            check_eq("wr_expected", int'(exp_addr_q.size() > 0), 1);
            if (exp_addr_q.size() > 0) begin
                a = exp_addr_q.pop_front();
                d = exp_data_q.pop_front();
                check_eq("wr_addr", int'(fb_write_addr), a);
                check_eq("wr_data", int'(fb_write_data), d);
            end
        end
        if (done) done_cnt++;
    end

    // Reference model: normalise, clip, enumerate pixels in raster order
    task automatic push_expected(input cmd_op_t op, input int x0, input int y0,
                                 input int x1, input int y1, input int color,
                                 output int n);
        int nx0, ny0, nx1, ny1;
        bit empty;
        nx0 = x0; ny0 = y0; nx1 = x1; ny1 = y1; empty = 1'b0; n = 0;
        case (op)
            OP_POINT: begin nx1 = x0; ny1 = y0; end
            OP_CLEAR: begin nx0 = 0; ny0 = 0; nx1 = FB_WIDTH - 1; ny1 = FB_HEIGHT - 1; end
            OP_RECT:  empty = 1'b0;
            default:  empty = 1'b1;
        endcase
        if (nx1 > FB_WIDTH - 1)  nx1 = FB_WIDTH - 1;
        if (ny1 > FB_HEIGHT - 1) ny1 = FB_HEIGHT - 1;
        if (nx0 >= FB_WIDTH || ny0 >= FB_HEIGHT || nx0 > nx1 || ny0 > ny1) empty = 1'b1;
        if (!empty) begin
            for (int y = ny0; y <= ny1; y++) begin
                for (int x = nx0; x <= nx1; x++) begin
                    exp_addr_q.push_back(y * FB_WIDTH + x);
                    exp_data_q.push_back(color);
                    n++;
                end
            end
        end
    endtask

    task automatic drive_fields(input cmd_op_t op, input int x0, input int y0,
                                input int x1, input int y1, input int color);
        cmd_if.cmd_op    = op;
        cmd_if.cmd_x0    = 8'(x0);
        cmd_if.cmd_y0    = 8'(y0);
        cmd_if.cmd_x1    = 8'(x1);
        cmd_if.cmd_y1    = 8'(y1);
        cmd_if.cmd_color = 3'(color);
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (!cmd_if.cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_ready_pre"}, int'(cmd_if.cmd_ready), 1);
    endtask

    task automatic run_cmd(input string tag, input cmd_op_t op, input int x0, input int y0,
                           input int x1, input int y1, input int color, input bit hold_valid);
        int n;
        int lat;
        int d0;
        push_expected(op, x0, y0, x1, y1, color, n);
        @(negedge clk);
        wait_ready(tag);
        drive_fields(op, x0, y0, x1, y1, color);
        cmd_if.cmd_valid = 1'b1;
        d0 = done_cnt;
        wr_cnt = 0;
        @(posedge clk);
        #1;
        if (!hold_valid) cmd_if.cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!done) begin
                check_eq({tag, "_busy"}, int'(cmd_if.cmd_ready), 0);
                if (hold_valid)
                    drive_fields(cmd_op_t'(2'($urandom_range(0, 3))), int'($urandom_range(0, 255)),
                                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                                 int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
            end
        end while (!done && lat <= n + 4);
        cmd_if.cmd_valid = 1'b0;
        check_eq({tag, "_done_lat"}, lat, n + 1);
        check_eq({tag, "_ready_fin"}, int'(cmd_if.cmd_ready), 0);
        check_eq({tag, "_wr_cnt"}, wr_cnt, n);
        check_eq({tag, "_q_empty"}, exp_addr_q.size(), 0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, int'(done), 0);
        check_eq({tag, "_ready_back"}, int'(cmd_if.cmd_ready), 1);
        check_eq({tag, "_done_cnt"}, done_cnt - d0, 1);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        int d0;
        n_rst_async      = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        drive_fields(OP_NOP, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_eq("rst_ready", int'(cmd_if.cmd_ready), 1);
        check_eq("rst_en",    int'(fb_write_en), 0);
        check_eq("rst_addr",  int'(fb_write_addr), 0);
        check_eq("rst_data",  int'(fb_write_data), 0);
        check_eq("rst_done",  int'(done), 0);
        n_rst_async = 1'b1;

        run_cmd("point",   OP_POINT, 5, 3, 0, 0, 6, 1'b0);
        run_cmd("rect",    OP_RECT, 10, 2, 12, 3, 1, 1'b0);
        check_eq("hold_addr", int'(fb_write_addr), 654);
        run_cmd("clip",    OP_RECT, 212, 158, 250, 200, 7, 1'b0);
        run_cmd("e_rect",  OP_RECT, 20, 0, 10, 5, 3, 1'b0);
        run_cmd("e_px",    OP_POINT, 214, 0, 0, 0, 5, 1'b0);
        run_cmd("e_py",    OP_POINT, 0, 160, 0, 0, 5, 1'b0);
        run_cmd("e_nop",   OP_NOP, 1, 1, 2, 2, 4, 1'b0);
        run_cmd("hold",    OP_RECT, 30, 40, 33, 42, 2, 1'b1);
        run_cmd("clear",   OP_CLEAR, 9, 9, 9, 9, 0, 1'b0);

        // Reset in the middle of a CLEAR
        push_expected(OP_CLEAR, 0, 0, 0, 0, 5, t);
        @(negedge clk);
        wait_ready("abort");
        drive_fields(OP_CLEAR, 0, 0, 0, 0, 5);
        cmd_if.cmd_valid = 1'b1;
        wr_cnt = 0;
        d0 = done_cnt;
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        t = 0;
        while (wr_cnt < 100 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("abort_wr100", wr_cnt, 100);
        #2 n_rst_async = 1'b0;
        #1;
        check_eq("abort_en",    int'(fb_write_en), 0);
        check_eq("abort_done",  int'(done), 0);
        check_eq("abort_ready", int'(cmd_if.cmd_ready), 1);
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (2) @(negedge clk);
        n_rst_async = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_ready2",  int'(cmd_if.cmd_ready), 1);
        run_cmd("after_rst", OP_POINT, 0, 0, 0, 0, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
